// File: rtl/dataflow_deadlock_monitor_if.sv
// Observation bundle for the dataflow deadlock monitor.
// master = monitored design/environment, slave = monitor.
interface dataflow_deadlock_monitor_if #(
   parameter int N_PROC = 4,
   parameter int IDW    = 2,
   parameter int CNT_W  = 16
);
   logic [N_PROC-1:0]        proc_blk;
   logic [N_PROC-1:0]        proc_done;
   logic [N_PROC*N_PROC-1:0] wait_vec;
   logic                     all_finish;
   logic                     clear;
   logic                     dl_detect;
   logic [IDW-1:0]           dl_origin;
   logic [IDW-1:0]           dl_entry;
   logic [N_PROC-1:0]        dl_visited;
   logic [CNT_W-1:0]         stall_cnt;
   logic                     busy;

   modport master (
      output proc_blk, proc_done, wait_vec, all_finish, clear,
      input  dl_detect, dl_origin, dl_entry, dl_visited, stall_cnt, busy
   );

   modport slave (
      input  proc_blk, proc_done, wait_vec, all_finish, clear,
      output dl_detect, dl_origin, dl_entry, dl_visited, stall_cnt, busy
   );
endinterface

// File: rtl/dataflow_deadlock_monitor.sv
// Deadlock monitor for N dataflow processes: qualifies a stable stall,
// then walks the wait-for graph one hop per cycle until a loop closes.
module dataflow_deadlock_monitor #(
   parameter int N_PROC       = 4,
   parameter int IDW          = 2,
   parameter int STALL_CYCLES = 16,
   parameter int CNT_W        = 16
) (
   input logic                        clock,
   input logic                        reset,
   dataflow_deadlock_monitor_if.slave mon
);

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      WALK,
      HOLDOFF,
      REPORT
   } state_t;

   state_t            state_q;
   logic [N_PROC-1:0] blk_prev_q;
   logic [CNT_W-1:0]  stall_cnt_q;
   logic [IDW-1:0]    origin_q;
   logic [IDW-1:0]    cur_q;
   logic [N_PROC-1:0] visited_q;
   logic [IDW-1:0]    hop_q;
   logic              busy_q;
   logic              dl_detect_q;
   logic [IDW-1:0]    dl_origin_q;
   logic [IDW-1:0]    dl_entry_q;
   logic [N_PROC-1:0] dl_visited_q;

   logic [N_PROC-1:0] blk_eff;
   logic              changed;
   logic [N_PROC-1:0] row;
   logic              nxt_hit;
   logic [IDW-1:0]    nxt_idx;
   logic              nxt_seen;
   logic [IDW-1:0]    org_idx;
   logic [CNT_W-1:0]  cnt_inc_d;

   function automatic logic [IDW-1:0] lsb_idx(input logic [N_PROC-1:0] v);
      logic [IDW-1:0] r;
      r = '0;
      for (int i = N_PROC - 1; i >= 0; i--) begin
         if (v[i]) r = IDW'(i);
      end
      return r;
   endfunction

   function automatic logic [N_PROC-1:0] onehot(input logic [IDW-1:0] i);
      return N_PROC'(1) << i;
   endfunction

   always_comb begin
      blk_eff   = mon.proc_blk & ~mon.proc_done;
      changed   = (blk_eff != blk_prev_q);
      row       = mon.wait_vec[int'(cur_q)*N_PROC +: N_PROC] & blk_eff;
      nxt_hit   = |row;
      nxt_idx   = lsb_idx(row);
      nxt_seen  = visited_q[nxt_idx];
      org_idx   = lsb_idx(blk_eff);
      cnt_inc_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         blk_prev_q   <= '0;
         stall_cnt_q  <= '0;
         origin_q     <= '0;
         cur_q        <= '0;
         visited_q    <= '0;
         hop_q        <= '0;
         busy_q       <= 1'b0;
         dl_detect_q  <= 1'b0;
         dl_origin_q  <= '0;
         dl_entry_q   <= '0;
         dl_visited_q <= '0;
      end else begin
         blk_prev_q <= blk_eff;
         if (mon.clear || mon.all_finish) begin
            state_q      <= IDLE;
            stall_cnt_q  <= '0;
            busy_q       <= 1'b0;
            dl_detect_q  <= 1'b0;
            dl_origin_q  <= '0;
            dl_entry_q   <= '0;
            dl_visited_q <= '0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (|blk_eff) begin
                     state_q     <= COUNT;
                     stall_cnt_q <= CNT_W'(1);
                  end else begin
                     stall_cnt_q <= '0;
                  end
               end
               COUNT: begin
                  if (changed || !(|blk_eff)) begin
                     state_q     <= IDLE;
                     stall_cnt_q <= '0;
                  end else begin
                     stall_cnt_q <= cnt_inc_d;
                     if (stall_cnt_q == CNT_W'(STALL_CYCLES - 1)) begin
                        state_q   <= WALK;
                        busy_q    <= 1'b1;
                        origin_q  <= org_idx;
                        cur_q     <= org_idx;
                        visited_q <= onehot(org_idx);
                        hop_q     <= '0;
                     end
                  end
               end
               WALK: begin
                  if (changed) begin
                     state_q     <= IDLE;
                     stall_cnt_q <= '0;
                     busy_q      <= 1'b0;
                  end else if (!nxt_hit) begin
                     state_q <= HOLDOFF;
                     busy_q  <= 1'b0;
                  end else if (nxt_seen) begin
                     state_q      <= REPORT;
                     busy_q       <= 1'b0;
                     dl_detect_q  <= 1'b1;
                     dl_origin_q  <= origin_q;
                     dl_entry_q   <= nxt_idx;
                     dl_visited_q <= visited_q;
                  end else if (hop_q == IDW'(N_PROC - 1)) begin
                     // every node already visited: graph is malformed
                     state_q <= HOLDOFF;
                     busy_q  <= 1'b0;
                  end else begin
                     visited_q <= visited_q | onehot(nxt_idx);
                     cur_q     <= nxt_idx;
                     hop_q     <= hop_q + 1'b1;
                  end
               end
               HOLDOFF: begin
                  if (changed) begin
                     state_q     <= IDLE;
                     stall_cnt_q <= '0;
                  end
               end
               REPORT: begin
                  state_q <= REPORT;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign mon.dl_detect  = dl_detect_q;
   assign mon.dl_origin  = dl_origin_q;
   assign mon.dl_entry   = dl_entry_q;
   assign mon.dl_visited = dl_visited_q;
   assign mon.stall_cnt  = stall_cnt_q;
   assign mon.busy       = busy_q;

endmodule

// File: tb/tb_dataflow_deadlock_monitor.sv
// Bench for dataflow_deadlock_monitor: directed scenarios plus random
// stimulus, every cycle compared against a path-based reference model.
module tb_dataflow_deadlock_monitor;
   localparam int N  = 4;
   localparam int SC = 8;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   dataflow_deadlock_monitor_if #(.N_PROC(N), .IDW(2), .CNT_W(16)) ifc ();

   dataflow_deadlock_monitor #(
      .N_PROC(N), .IDW(2), .STALL_CYCLES(SC), .CNT_W(16)
   ) dut (
      .clock(clock),
      .reset(reset),
      .mon  (ifc.slave)
   );

   always #5 clock = ~clock;

   // reference model: the walk is a list of visited processes
   bit [N-1:0] m_prev;
   int         m_cnt;
   int         path[$];
   bit         m_hold, m_rep, m_det;
   int         m_org, m_ent;
   bit [N-1:0] m_vis;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lowest(input bit [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_prev = '0; m_cnt = 0; path.delete();
      m_hold = 0; m_rep = 0; m_det = 0;
      m_org = 0; m_ent = 0; m_vis = '0;
   endtask

   task automatic model_step();
      bit [N-1:0] beff;
      bit [N-1:0] rowv;
      bit         chg;
      bit         seen;
      int         c, s;
      beff = ifc.proc_blk & ~ifc.proc_done;
      chg  = (beff != m_prev);
      if (ifc.clear || ifc.all_finish) begin
         m_cnt = 0; path.delete(); m_hold = 0; m_rep = 0;
         m_det = 0; m_org = 0; m_ent = 0; m_vis = '0;
      end else if (m_rep) begin
         m_rep = 1;
      end else if (path.size() != 0) begin
         if (chg) begin
            path.delete(); m_cnt = 0;
         end else begin
            c    = path[path.size()-1];
            rowv = ifc.wait_vec[c*N +: N] & beff;
            s    = lowest(rowv);
            seen = 0;
            foreach (path[j]) if (path[j] == s) seen = 1;
            if (s < 0) begin
               path.delete(); m_hold = 1;
            end else if (seen) begin
               m_det = 1; m_org = path[0]; m_ent = s; m_vis = '0;
               foreach (path[j]) m_vis[path[j]] = 1'b1;
               path.delete(); m_rep = 1;
            end else if (path.size() == N) begin
               path.delete(); m_hold = 1;
            end else begin
               path.push_back(s);
            end
         end
      end else if (m_hold) begin
         if (chg) begin m_hold = 0; m_cnt = 0; end
      end else if (m_cnt == 0) begin
         if (beff != 0) m_cnt = 1;
      end else if (chg || beff == 0) begin
         m_cnt = 0;
      end else begin
         if (m_cnt == SC - 1) path.push_back(lowest(beff));
         if (m_cnt < 65535) m_cnt++;
      end
      m_prev = beff;
   endtask

   task automatic cmp_all();
      check("detect",  32'(ifc.dl_detect),  32'(m_det));
      check("origin",  32'(ifc.dl_origin),  32'(m_org));
      check("entry",   32'(ifc.dl_entry),   32'(m_ent));
      check("visited", 32'(ifc.dl_visited), 32'(m_vis));
      check("stall",   32'(ifc.stall_cnt),  32'(m_cnt));
      check("busy",    32'(ifc.busy),       32'(path.size() != 0));
   endtask

   task automatic step();
      @(posedge clock);
      model_step();
      #1;
      cmp_all();
   endtask

   task automatic idle_in();
      ifc.proc_blk = '0; ifc.proc_done = '0; ifc.wait_vec = '0;
      ifc.all_finish = 1'b0; ifc.clear = 1'b0;
   endtask

   task automatic quiesce();
      idle_in();
      ifc.clear = 1'b1;
      step();
      ifc.clear = 1'b0;
      step();
      step();
   endtask

   task automatic set_loop();
      ifc.proc_blk = 4'b1110;
      ifc.wait_vec = '0;
      ifc.wait_vec[1*N+3] = 1'b1;
      ifc.wait_vec[3*N+2] = 1'b1;
      ifc.wait_vec[2*N+1] = 1'b1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_det"},  32'(ifc.dl_detect),  0);
      check({tag, "_org"},  32'(ifc.dl_origin),  0);
      check({tag, "_ent"},  32'(ifc.dl_entry),   0);
      check({tag, "_vis"},  32'(ifc.dl_visited), 0);
      check({tag, "_cnt"},  32'(ifc.stall_cnt),  0);
      check({tag, "_busy"}, 32'(ifc.busy),       0);
   endtask

   initial begin
      idle_in();
      model_reset();
      #12;
      check_zero("rst");
      @(negedge clock) reset = 1'b1;
      step(); step();

      // loop 1->3->2->1
      set_loop();
      repeat (8) step();
      check("loop_walk", 32'(ifc.busy), 1);
      step(); step();
      check("loop_early", 32'(ifc.dl_detect), 0);
      step();
      check("loop_det", 32'(ifc.dl_detect), 1);
      check("loop_org", 32'(ifc.dl_origin), 1);
      check("loop_ent", 32'(ifc.dl_entry), 1);
      check("loop_vis", 32'(ifc.dl_visited), 32'b1110);
      ifc.proc_blk = 4'b0101;
      repeat (4) step();
      check("loop_hold", 32'(ifc.dl_detect), 1);
      ifc.clear = 1'b1;
      step();
      ifc.clear = 1'b0;
      check_zero("clr");
      quiesce();

      // chain 0->1, no loop
      ifc.proc_blk = 4'b0011;
      ifc.wait_vec[0*N+1] = 1'b1;
      repeat (13) step();
      check("chain_det", 32'(ifc.dl_detect), 0);
      check("chain_busy", 32'(ifc.busy), 0);
      check("chain_cnt", 32'(ifc.stall_cnt), SC);
      ifc.proc_blk = 4'b1011;
      step();
      check("chain_rel", 32'(ifc.stall_cnt), 0);
      ifc.proc_blk = 4'b0011;
      step();
      quiesce();

      // transient stall
      ifc.proc_blk = 4'b0101;
      repeat (5) step();
      check("tr_cnt5", 32'(ifc.stall_cnt), 5);
      ifc.proc_blk = 4'b0111;
      step();
      check("tr_cnt0", 32'(ifc.stall_cnt), 0);
      repeat (6) step();
      check("tr_cnt6", 32'(ifc.stall_cnt), 6);
      check("tr_busy", 32'(ifc.busy), 0);
      quiesce();

      // abort during hop 1
      set_loop();
      repeat (8) step();
      ifc.proc_blk = 4'b1111;
      step();
      check("ab_busy", 32'(ifc.busy), 0);
      check("ab_cnt", 32'(ifc.stall_cnt), 0);
      repeat (3) step();
      check("ab_det", 32'(ifc.dl_detect), 0);
      quiesce();

      // loop 0<->1 masked by done
      ifc.proc_blk = 4'b0011;
      ifc.proc_done = 4'b0010;
      ifc.wait_vec[0*N+1] = 1'b1;
      ifc.wait_vec[1*N+0] = 1'b1;
      repeat (14) step();
      check("mask_det", 32'(ifc.dl_detect), 0);
      // same loop, all_finish on the closing cycle
      ifc.proc_done = '0;
      ifc.clear = 1'b1;
      step();
      ifc.clear = 1'b0;
      repeat (9) step();
      ifc.all_finish = 1'b1;
      step();
      check("fin_det", 32'(ifc.dl_detect), 0);
      ifc.all_finish = 1'b0;
      step();
      check("fin_det2", 32'(ifc.dl_detect), 0);
      quiesce();

      // reset mid-walk
      set_loop();
      repeat (9) step();
      check("rw_busy", 32'(ifc.busy), 1);
      reset = 1'b0;
      #1;
      check_zero("rw");
      model_reset();
      idle_in();
      @(negedge clock) reset = 1'b1;
      step();
      check("rw_idle", 32'(ifc.busy), 0);

      // random segments
      for (int seg = 0; seg < 80; seg++) begin
         ifc.proc_blk  = N'($urandom);
         ifc.proc_done = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         ifc.wait_vec  = 16'($urandom);
         for (int k = 0; k < int'($urandom_range(2, 24)); k++) begin
            ifc.clear      = ($urandom_range(0, 40) == 0);
            ifc.all_finish = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 9) == 0)
               ifc.wait_vec[$urandom_range(0, 15)] ^= 1'b1;
            if ($urandom_range(0, 30) == 0)
               ifc.proc_blk[$urandom_range(0, 3)] ^= 1'b1;
            step();
         end
         ifc.clear = 1'b0;
         ifc.all_finish = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/dataflow_deadlock_monitor.md
Name: dataflow_deadlock_monitor

Overview:
- Parametrised simulation-side deadlock monitor for N dataflow processes in a generated HLS design.
- Watches per-process blocked flags and a wait-for matrix, and qualifies a stall by requiring a stable blocked set for STALL_CYCLES cycles.
- Confirms a deadlock by walking the wait-for graph one hop per cycle until a loop closes.
- Reports a sticky deadlock flag, origin, loop-entry process and visited set; successor to the fixed 4-process detector, with a stall threshold, cycle-walk FSM and a clear input.

Parameters:
- N_PROC, 4, number of monitored processes (2..32).
- IDW, 2, index width = clog2(N_PROC).
- STALL_CYCLES, 16, cycles the blocked set must stay stable before a walk starts (>=2).
- CNT_W, 16, stall counter width; must hold STALL_CYCLES.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- proc_blk  in  N_PROC  bit i = process i blocked on a channel this cycle.
- proc_done  in  N_PROC  bit i = process i finished (ap_done held); done processes are masked out of proc_blk.
- wait_vec  in  N_PROC*N_PROC  row i (bits i*N+N-1..i*N) = processes i is waiting on.
- all_finish  in  1  design finished; suppresses detection.
- clear  in  1  synchronous clear of sticky report and FSM.
- dl_detect  out  1  sticky deadlock flag.
- dl_origin  out  IDW  walk start process.
- dl_entry  out  IDW  process where the loop closed.
- dl_visited  out  N_PROC  processes visited by the walk.
- stall_cnt  out  CNT_W  current stable-stall count.
- busy  out  1  high in WALK state.

Behaviour:
- Reset (async, reset=0): state IDLE, all outputs 0, blk_prev=0, hop=0.
- blk_eff = proc_blk & ~proc_done; blk_prev registers blk_eff every cycle; changed = (blk_eff != blk_prev).
- Priority each cycle, highest first: reset, clear, all_finish, then FSM. clear or all_finish forces IDLE, zeroes stall_cnt/dl_*. all_finish wins over a same-cycle loop close.
- States: IDLE, COUNT, WALK, HOLDOFF, REPORT.
- IDLE:
  - blk_eff!=0 -> COUNT with stall_cnt=1.
  - else stall_cnt=0.
- COUNT:
  - changed or blk_eff==0 -> stall_cnt=0, IDLE.
  - else stall_cnt++ (saturating at all-ones).
  - On stall_cnt==STALL_CYCLES-1 and stable -> WALK next edge.
  - On WALK entry: origin=lowest set bit of blk_eff, cur=origin, visited=onehot(origin), hop=0.
- WALK (one hop per cycle, busy=1):
  - nxt = lowest set bit of (wait_vec row cur & blk_eff).
  - changed -> abort to IDLE, stall_cnt=0.
  - No nxt -> HOLDOFF.
  - nxt in visited -> REPORT; dl_detect=1, dl_origin=origin, dl_entry=nxt, dl_visited=visited, registered on that edge.
  - Otherwise visited|=onehot(nxt), cur=nxt, hop++.
  - hop==N_PROC-1 without closing -> HOLDOFF (cannot occur with a well-formed graph; guard only).
- HOLDOFF: no re-walk until changed; then stall_cnt=0, IDLE. stall_cnt holds its value.
- REPORT:
  - All dl_* outputs hold regardless of inputs until clear or all_finish.
  - stall_cnt holds. No further walks.
- Latency: with a stable blocked set from cycle t0 (first cycle blk_eff!=0 in IDLE), WALK entered at t0+STALL_CYCLES. A k-edge loop reached from origin in k hops asserts dl_detect at the edge ending cycle t0+STALL_CYCLES+k-1.
- Self-loop (wait_vec row i bit i, i blocked) counts as a 1-hop loop with dl_entry=i.
- The monitor never drives design signals; it is observation only.

Test Plan:
- N_PROC=4, STALL_CYCLES=8. Reset mid-WALK:
  - Stimulus: assert reset=0 while busy=1.
  - Response: all outputs 0 immediately, IDLE after release.
- Loop 1->3->2->1, proc_blk=4'b1110, wait rows 1:{3}, 3:{2}, 2:{1}, held from cycle 0:
  - WALK entered at cycle 8.
  - dl_detect=1 after 3 hops, dl_origin=1, dl_entry=1, dl_visited=4'b1110.
  - Outputs hold until clear; clear -> all zero next cycle.
- Chain, no loop: proc_blk=4'b0011, 0 waits on 1, 1 waits on nothing:
  - Walk ends in HOLDOFF, dl_detect stays 0.
  - Toggling proc_blk[3] returns FSM to IDLE with stall_cnt=0.
- Transient stall: blocked set changes at stall_cnt=5 -> stall_cnt=0, no WALK entered.
- Abort mid-WALK: proc_blk changes during hop 1 -> IDLE, dl_detect=0.
- Masking and suppression:
  - Loop 0<->1 with proc_done[1]=1 -> no detection.
  - Same loop with proc_done=0 and all_finish=1 on the closing cycle -> dl_detect stays 0.
